// File: rtl/forward_ctrl.sv
// Operand-forwarding and load-use hazard controller: shadow EX/MEM/WB destination tracking,
// registered EX operand selects, load-use stall and stall counter. Macro: FWD_WB_BYPASS_EN.
module forward_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        stall_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [1:0] SEL_ID   = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_EX   = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  logic       ex_v_q, ex_rw_q, ex_mr_q;
  logic [4:0] ex_rd_q;
  logic       mem_v_q, mem_rw_q;
  logic [4:0] mem_rd_q;
`ifdef FWD_WB_BYPASS_EN
  logic       wb_v_q, wb_rw_q;
  logic [4:0] wb_rd_q;
`endif
  logic [1:0]  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        id_go;

  function automatic logic writes(input logic v, input logic rw, input logic [4:0] rd,
                                  input logic [4:0] r);
    return v & rw & (rd == r) & (rd != 5'd0);
  endfunction

  function automatic logic [1:0] pick(input logic use_r, input logic [4:0] r,
                                      input logic hit_ex, input logic hit_mem,
                                      input logic hit_wb);
    if (!use_r || r == 5'd0) return SEL_ID;
    if (hit_ex)              return SEL_EX;
    if (hit_mem)             return SEL_WB;
    if (hit_wb)              return SEL_HOLD;
    return SEL_ID;
  endfunction

  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;

  always_comb begin
    ex_a  = writes(ex_v_q, ex_rw_q, ex_rd_q, id_rs1_i);
    ex_b  = writes(ex_v_q, ex_rw_q, ex_rd_q, id_rs2_i);
    mem_a = writes(mem_v_q, mem_rw_q, mem_rd_q, id_rs1_i);
    mem_b = writes(mem_v_q, mem_rw_q, mem_rd_q, id_rs2_i);
`ifdef FWD_WB_BYPASS_EN
    wb_a  = writes(wb_v_q, wb_rw_q, wb_rd_q, id_rs1_i);
    wb_b  = writes(wb_v_q, wb_rw_q, wb_rd_q, id_rs2_i);
`else
    // Write-first register file: WB results are already visible through the ID/EX operand.
    wb_a  = 1'b0;
    wb_b  = 1'b0;
`endif
  end

  // A flushed instruction never stalls; it simply becomes a bubble.
  assign stall_o = id_valid_i & ~flush_i & ex_v_q & ex_mr_q & (ex_rd_q != 5'd0) &
                   ((id_use_rs1_i & (id_rs1_i == ex_rd_q)) |
                    (id_use_rs2_i & (id_rs2_i == ex_rd_q)));

  assign id_go = id_valid_i & ~flush_i & ~stall_o;

  always_comb begin
    fwd_a_d     = SEL_ID;
    fwd_b_d     = SEL_ID;
    stall_cnt_d = stall_cnt_q;
    if (id_go) begin
      fwd_a_d = pick(id_use_rs1_i, id_rs1_i, ex_a, mem_a, wb_a);
      fwd_b_d = pick(id_use_rs2_i, id_rs2_i, ex_b, mem_b, wb_b);
    end
    if (stall_o && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // ID -> EX -> MEM -> WB shadow advance; everything freezes under hold_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_v_q      <= 1'b0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_rd_q     <= 5'd0;
      mem_v_q     <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_rd_q    <= 5'd0;
`ifdef FWD_WB_BYPASS_EN
      wb_v_q      <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
`endif
      fwd_a_q     <= SEL_ID;
      fwd_b_q     <= SEL_ID;
      stall_cnt_q <= 16'd0;
    end else if (!hold_i) begin
      ex_v_q      <= id_go;
      ex_rw_q     <= id_regwrite_i;
      ex_mr_q     <= id_memread_i;
      ex_rd_q     <= id_rd_i;
      mem_v_q     <= ex_v_q;
      mem_rw_q    <= ex_rw_q;
      mem_rd_q    <= ex_rd_q;
`ifdef FWD_WB_BYPASS_EN
      wb_v_q      <= mem_v_q;
      wb_rw_q     <= mem_rw_q;
      wb_rd_q     <= mem_rd_q;
`endif
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a_o     = fwd_a_q;
  assign fwd_b_o     = fwd_b_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed literal sequences, then randomized traffic against
// a history-based reference model of in-flight instructions.
module tb_forward_ctrl;

`ifdef FWD_WB_BYPASS_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic        id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0;
  logic        id_regwrite_i = 1'b0, id_memread_i = 1'b0;
  logic        flush_i = 1'b0, hold_i = 1'b0;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;

  forward_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .hold_i(hold_i),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit v; bit [4:0] rd; bit rw; bit mr; } ent_t;
  ent_t    hist[3];      // hist[0] = instruction in EX, [1] = MEM, [2] = WB
  bit [1:0] m_a, m_b;
  int       m_cnt;
  int       checks = 0, errors = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 5'd0, 1'b0, 1'b0};
    m_a = 2'd0; m_b = 2'd0; m_cnt = 0;
  endfunction

  function automatic bit model_stall();
    if (!id_valid_i || flush_i) return 1'b0;
    if (!(hist[0].v && hist[0].mr) || hist[0].rd == 5'd0) return 1'b0;
    return (id_use_rs1_i && id_rs1_i == hist[0].rd) || (id_use_rs2_i && id_rs2_i == hist[0].rd);
  endfunction

  // Most recent in-flight writer of r decides the source, by its age.
  function automatic bit [1:0] model_sel(input bit use_r, input bit [4:0] r);
    if (!use_r || r == 5'd0) return 2'd0;
    for (int age = 0; age < 3; age++)
      if (hist[age].v && hist[age].rw && hist[age].rd == r)
        return (age == 0) ? 2'd2 : (age == 1) ? 2'd1 : (WB_EN ? 2'd3 : 2'd0);
    return 2'd0;
  endfunction

  function automatic void model_clock();
    bit s, go;
    if (hold_i) return;
    s  = model_stall();
    go = id_valid_i && !flush_i && !s;
    m_a = go ? model_sel(id_use_rs1_i, id_rs1_i) : 2'd0;
    m_b = go ? model_sel(id_use_rs2_i, id_rs2_i) : 2'd0;
    if (s && m_cnt < 16'hFFFF) m_cnt++;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '{go, id_rd_i, id_regwrite_i, id_memread_i};
  endfunction

  // Continuous comparison, mid-cycle.
  always @(negedge clk_i) begin
    chk("model_fwd_a", fwd_a_o, m_a);
    chk("model_fwd_b", fwd_b_o, m_b);
    chk("model_stall", stall_o, model_stall());
    chk("model_cnt", stall_cnt_o, m_cnt);
  end

  task automatic tick();
    @(posedge clk_i);
    if (rst_i) model_clock();
    #1;
  endtask

  task automatic drive(input bit v, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                       input bit u2, input bit [4:0] rd, input bit rw, input bit mr,
                       input bit fl, input bit hd);
    id_valid_i = v; id_rs1_i = rs1; id_use_rs1_i = u1; id_rs2_i = rs2; id_use_rs2_i = u2;
    id_rd_i = rd; id_regwrite_i = rw; id_memread_i = mr; flush_i = fl; hold_i = hd;
  endtask

  task automatic issue(input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2,
                       input bit [4:0] rd, input bit rw, input bit mr);
    drive(1'b1, rs1, u1, rs2, u2, rd, rw, mr, 1'b0, 1'b0);
    tick();
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    model_clear();
    #2;
    chk("reset_fwd_a", fwd_a_o, 0);
    chk("reset_fwd_b", fwd_b_o, 0);
    chk("reset_stall", stall_o, 0);
    chk("reset_cnt", stall_cnt_o, 0);
    tick(); tick();
    rst_i = 1'b1;
    nop(); nop(); nop();

    // add x5 ; sub x8, x5, x6
    issue(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    drive(1'b1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 0);
    #1 chk("dep_stall", stall_o, 0);
    tick();
    chk("dep_fwd_a", fwd_a_o, 2);
    chk("dep_fwd_b", fwd_b_o, 0);

    // producer x7, one independent, consumer rs2=x7
    issue(5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
    issue(5'd11, 1, 5'd12, 1, 5'd10, 1, 0);
    issue(5'd13, 1, 5'd7, 1, 5'd14, 1, 0);
    chk("mem_fwd_b", fwd_b_o, 1);
    // producer x7, two independent, consumer rs2=x7
    issue(5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
    issue(5'd11, 1, 5'd12, 1, 5'd10, 1, 0);
    issue(5'd11, 1, 5'd12, 1, 5'd10, 1, 0);
    issue(5'd13, 1, 5'd7, 1, 5'd14, 1, 0);
    chk("wb_fwd_b", fwd_b_o, WB_EN ? 3 : 0);

    // lw x3 ; add rs1=x3
    issue(5'd1, 1, 5'd0, 0, 5'd3, 1, 1);
    drive(1'b1, 5'd3, 1, 5'd4, 1, 5'd9, 1, 0, 0, 0);
    #1 chk("lu_stall_on", stall_o, 1);
    chk("lu_cnt_before", stall_cnt_o, 0);
    tick();
    chk("lu_cnt_after", stall_cnt_o, 1);
    chk("lu_bubble_fwd_a", fwd_a_o, 0);
    chk("lu_stall_off", stall_o, 0);
    tick();
    chk("lu_fwd_a", fwd_a_o, 1);

    // x0 producer / unused rs2
    issue(5'd1, 1, 5'd2, 1, 5'd0, 1, 0);
    issue(5'd0, 1, 5'd2, 1, 5'd15, 1, 0);
    chk("x0_fwd_a", fwd_a_o, 0);
    issue(5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
    issue(5'd4, 1, 5'd9, 0, 5'd15, 1, 0);
    chk("unused_fwd_b", fwd_b_o, 0);

    // load-use under flush
    issue(5'd1, 1, 5'd0, 0, 5'd3, 1, 1);
    drive(1'b1, 5'd3, 1, 5'd4, 1, 5'd9, 1, 0, 1, 0);
    #1 chk("flush_stall", stall_o, 0);
    tick();
    chk("flush_cnt", stall_cnt_o, 1);
    chk("flush_fwd_a", fwd_a_o, 0);

    // hold over a dependency
    issue(5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
    drive(1'b1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 1);
    tick(); tick();
    chk("hold_fwd_a", fwd_a_o, 0);
    hold_i = 1'b0;
    tick();
    chk("release_fwd_a", fwd_a_o, 2);

    // reset mid-stream
    issue(5'd1, 1, 5'd2, 1, 5'd6, 1, 0);
    issue(5'd6, 1, 5'd2, 1, 5'd8, 1, 0);
    chk("pre_rst_fwd_a", fwd_a_o, 2);
    rst_i = 1'b0;
    model_clear();
    #1;
    chk("rst_fwd_a", fwd_a_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    tick();
    rst_i = 1'b1;
    issue(5'd6, 1, 5'd2, 1, 5'd8, 1, 0);
    chk("post_rst_fwd_a", fwd_a_o, 0);

    // randomized traffic over a small register space to provoke hazards
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(99) < 85, 5'($urandom_range(3)), 1'($urandom_range(1)),
            5'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(3)),
            $urandom_range(99) < 80, $urandom_range(99) < 35,
            $urandom_range(99) < 8, $urandom_range(99) < 10);
      if ($urandom_range(999) == 0) begin
        rst_i = 1'b0;
        model_clear();
      end else begin
        rst_i = 1'b1;
      end
      tick();
    end
    rst_i = 1'b1;
    nop();
    @(negedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
